// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: ALU control encodings, LEGv8 opcode constants and issue FSM states
package alu_issue_ctrl_pkg;
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_MOVZ  = 4'b1100;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [8:0]  OP_MOVZ = 9'b110100101;
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational LEGv8 decode to ALU opcode, operand B and illegal flag
module alu_op_decode
   import alu_issue_ctrl_pkg::*;
#(
   parameter int n = 64
) (
   input  logic [31:0]  instr_i,
   input  logic [n-1:0] regb_i,
   output logic [3:0]   alu_ctrl_o,
   output logic [n-1:0] alu_b_o,
   output logic         illegal_o,
   output logic         cbz_o
);
   logic [10:0] op;
   logic        unused_rd;
   assign op        = instr_i[31:21];
   assign unused_rd = ^instr_i[4:0];
   always_comb begin
      alu_ctrl_o = ALU_PASSB;
      alu_b_o    = regb_i;
      illegal_o  = 1'b0;
      cbz_o      = 1'b0;
      if (op == OP_ADD) alu_ctrl_o = ALU_ADD;
      else if (op == OP_SUB) alu_ctrl_o = ALU_SUB;
      else if (op == OP_AND) alu_ctrl_o = ALU_AND;
      else if (op == OP_ORR) alu_ctrl_o = ALU_OR;
      else if (op == OP_LDUR || op == OP_STUR) begin
         alu_ctrl_o = ALU_ADD;
         alu_b_o    = {{(n-9){instr_i[20]}}, instr_i[20:12]};
      end
      else if (instr_i[31:24] == OP_CBZ) cbz_o = 1'b1;
      else if (instr_i[31:23] == OP_MOVZ) begin
         // hw field selects the 16-bit lane the ALU shifts the immediate into
         alu_ctrl_o = ALU_MOVZ | {2'b00, instr_i[22:21]};
         alu_b_o    = {{(n-16){1'b0}}, instr_i[20:5]};
      end
      else illegal_o = 1'b1;
   end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-in-flight issue controller that drives an external ALU,
// waits LAT cycles for it to settle, then holds the captured result until taken.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int n   = 64,
   parameter int LAT = 2
) (
   input  logic         CLK,
   input  logic         ResetL,
   input  logic         InstrValid,
   output logic         InstrReady,
   input  logic [31:0]  Instr,
   input  logic [n-1:0] RegA,
   input  logic [n-1:0] RegB,
   output logic [3:0]   AluCtrl,
   output logic [n-1:0] AluA,
   output logic [n-1:0] AluB,
   input  logic [n-1:0] AluW,
   input  logic         AluZero,
   output logic         ResValid,
   input  logic         ResReady,
   output logic [n-1:0] ResData,
   output logic         ResZero,
   output logic         ResTaken,
   output logic         ResIllegal
);
   localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d, ctrl_q, ctrl_d, dec_ctrl;
   logic [n-1:0] a_q, a_d, b_q, b_d, data_q, data_d, dec_b;
   logic         zero_q, zero_d, taken_q, taken_d, ill_q, ill_d, cbz_q, cbz_d;
   logic         live_q, dec_ill, dec_cbz;

   alu_op_decode #(.n(n)) u_dec (
      .instr_i    (Instr),
      .regb_i     (RegB),
      .alu_ctrl_o (dec_ctrl),
      .alu_b_o    (dec_b),
      .illegal_o  (dec_ill),
      .cbz_o      (dec_cbz)
   );

   // live_q keeps InstrReady low until the first edge after reset release
   always_ff @(posedge CLK or negedge ResetL) begin
      if (!ResetL) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ctrl_q  <= ALU_PASSB;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         zero_q  <= 1'b0;
         taken_q <= 1'b0;
         ill_q   <= 1'b0;
         cbz_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         taken_q <= taken_d;
         ill_q   <= ill_d;
         cbz_q   <= cbz_d;
         live_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_d  = ctrl_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      zero_d  = zero_q;
      taken_d = taken_q;
      ill_d   = ill_q;
      cbz_d   = cbz_q;
      case (state_q)
         IDLE: if (InstrValid && InstrReady) begin
            data_d  = '0;
            zero_d  = 1'b0;
            taken_d = 1'b0;
            ill_d   = dec_ill;
            cbz_d   = dec_cbz;
            cnt_d   = '0;
            state_d = dec_ill ? DONE : EXEC;
            if (!dec_ill) begin
               ctrl_d = dec_ctrl;
               a_d    = RegA;
               b_d    = dec_b;
            end
         end
         EXEC: if (cnt_q == LAT_M1) begin
            data_d  = AluW;
            zero_d  = AluZero;
            taken_d = cbz_q & AluZero;
            cnt_d   = '0;
            state_d = DONE;
         end else cnt_d = cnt_q + 4'd1;
         DONE: if (ResReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign InstrReady = live_q && (state_q == IDLE);
   assign ResValid   = (state_q == DONE);
   assign AluCtrl    = ctrl_q;
   assign AluA       = a_q;
   assign AluB       = b_q;
   assign ResData    = data_q;
   assign ResZero    = zero_q;
   assign ResTaken   = taken_q;
   assign ResIllegal = ill_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized check of alu_issue_ctrl against a
// transaction-level model, with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;
   localparam int N   = 64;
   localparam int LAT = 3;

   logic          CLK = 1'b0, ResetL = 1'b1, InstrValid = 1'b0, ResReady = 1'b1;
   logic          InstrReady, AluZero, ResValid, ResZero, ResTaken, ResIllegal;
   logic [31:0]   Instr = '0;
   logic [N-1:0]  RegA = '0, RegB = '0, AluA, AluB, AluW, ResData;
   logic [3:0]    AluCtrl;
   int            n_cmp = 0, n_err = 0, cyc = 0, since_rst = 0;

   typedef struct {
      logic [3:0]  ctrl;
      logic [63:0] a, b, data;
      logic        zero, taken, ill;
   } exp_t;

   alu_issue_ctrl #(.n(N), .LAT(LAT)) dut (
      .CLK(CLK), .ResetL(ResetL), .InstrValid(InstrValid), .InstrReady(InstrReady),
      .Instr(Instr), .RegA(RegA), .RegB(RegB), .AluCtrl(AluCtrl), .AluA(AluA),
      .AluB(AluB), .AluW(AluW), .AluZero(AluZero), .ResValid(ResValid),
      .ResReady(ResReady), .ResData(ResData), .ResZero(ResZero),
      .ResTaken(ResTaken), .ResIllegal(ResIllegal)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      case (AluCtrl)
         4'b0000: AluW = AluA & AluB;
         4'b0001: AluW = AluA | AluB;
         4'b0010: AluW = AluA + AluB;
         4'b0110: AluW = AluA - AluB;
         4'b0111: AluW = AluB;
         default: AluW = (AluCtrl[3:2] == 2'b11) ? AluB << {AluCtrl[1:0], 4'b0000} : '0;
      endcase
      AluZero = (AluW == '0);
   end

   function automatic exp_t model(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      logic [10:0] op;
      logic cbz;
      op = i[31:21];
      cbz = 1'b0;
      e.ill = 1'b0; e.a = a; e.b = b; e.ctrl = 4'b0111; e.data = '0;
      if (op == 11'b10001011000) begin e.ctrl = 4'b0010; e.data = a + b; end
      else if (op == 11'b11001011000) begin e.ctrl = 4'b0110; e.data = a - b; end
      else if (op == 11'b10001010000) begin e.ctrl = 4'b0000; e.data = a & b; end
      else if (op == 11'b10101010000) begin e.ctrl = 4'b0001; e.data = a | b; end
      else if (op == 11'b11111000010 || op == 11'b11111000000) begin
         e.ctrl = 4'b0010;
         e.b = {{55{i[20]}}, i[20:12]};
         e.data = a + e.b;
      end
      else if (i[31:24] == 8'hB4) begin cbz = 1'b1; e.data = b; end
      else if (i[31:23] == 9'b110100101) begin
         e.ctrl = {2'b11, i[22:21]};
         e.b = {48'h0, i[20:5]};
         e.data = e.b << (16 * int'(i[22:21]));
      end
      else e.ill = 1'b1;
      e.zero  = !e.ill && (e.data == 0);
      e.taken = cbz && e.zero;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      since_rst <= ResetL ? since_rst + 1 : 0;
   end

   // Scoreboard: one pending transaction, its result due a fixed number of cycles after acceptance
   logic pend = 1'b0;
   exp_t ex;
   int   due = 0;
   always @(negedge CLK) begin
      if (!ResetL) begin
         pend = 1'b0;
         chk("rst_ready", 64'(InstrReady), 0);
         chk("rst_valid", 64'(ResValid), 0);
         chk("rst_ctrl", 64'(AluCtrl), 64'h7);
         chk("rst_alua", AluA, 0);
         chk("rst_alub", AluB, 0);
         chk("rst_data", ResData, 0);
         chk("rst_flags", 64'({ResZero, ResTaken, ResIllegal}), 0);
      end else if (!pend) begin
         chk("idle_ready", 64'(InstrReady), 64'(since_rst >= 1));
         chk("idle_valid", 64'(ResValid), 0);
         if (InstrValid && InstrReady) begin
            ex = model(Instr, RegA, RegB);
            pend = 1'b1;
            due = cyc + (ex.ill ? 1 : LAT + 1);
         end
      end else begin
         chk("busy_ready", 64'(InstrReady), 0);
         chk("valid_time", 64'(ResValid), 64'(cyc >= due));
         if (cyc < due) begin
            chk("exec_ctrl", 64'(AluCtrl), 64'(ex.ctrl));
            chk("exec_alua", AluA, ex.a);
            chk("exec_alub", AluB, ex.b);
         end else begin
            chk("res_data", ResData, ex.data);
            chk("res_flags", 64'({ResZero, ResTaken, ResIllegal}), 64'({ex.zero, ex.taken, ex.ill}));
            if (ResReady) pend = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b, output int lat);
      int k;
      Instr = i; RegA = a; RegB = b; InstrValid = 1'b1;
      k = 0;
      while (!InstrReady && k < 50) begin step(); k++; end
      if (k >= 50) chk("accept_timeout", 64'(InstrReady), 1);
      step();
      InstrValid = 1'b0;
      lat = 1;
      while (!ResValid && lat < 50) begin step(); lat++; end
   endtask

   task automatic run(input string nm, input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] ectrl, input logic [63:0] eb, input logic [63:0] edata,
                      input logic ezero, input logic etaken, input logic eill, input int elat);
      exp_t e;
      int lat;
      e = model(i, a, b);
      chk({nm, "_model_data"}, e.data, edata);
      chk({nm, "_model_flags"}, 64'({e.zero, e.taken, e.ill}), 64'({ezero, etaken, eill}));
      ResReady = 1'b1;
      issue(i, a, b, lat);
      chk({nm, "_latency"}, 64'(lat), 64'(elat));
      chk({nm, "_data"}, ResData, edata);
      chk({nm, "_flags"}, 64'({ResZero, ResTaken, ResIllegal}), 64'({ezero, etaken, eill}));
      if (!eill) begin
         chk({nm, "_ctrl"}, 64'(AluCtrl), 64'(ectrl));
         chk({nm, "_alub"}, AluB, eb);
      end
      step();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 8))
         0: return {11'b10001011000, r[20:0]};
         1: return {11'b11001011000, r[20:0]};
         2: return {11'b10001010000, r[20:0]};
         3: return {11'b10101010000, r[20:0]};
         4: return {11'b11111000010, r[20:0]};
         5: return {11'b11111000000, r[20:0]};
         6: return {8'hB4, r[23:0]};
         7: return {9'b110100101, r[22:0]};
         default: return r;
      endcase
   endfunction

   initial begin
      int lat;
      #1 ResetL = 1'b0;
      repeat (3) step();
      ResetL = 1'b1;
      step();
      run("add", {11'b10001011000, 21'h0}, 64'd5, 64'd7, 4'b0010, 64'd7, 64'd12, 0, 0, 0, LAT + 1);
      run("sub_zero", {11'b11001011000, 21'h0}, 64'd5, 64'd5, 4'b0110, 64'd5, 64'd0, 1, 0, 0, LAT + 1);
      run("cbz_taken", {8'hB4, 24'h0}, 64'd9, 64'd0, 4'b0111, 64'd0, 64'd0, 1, 1, 0, LAT + 1);
      run("cbz_not", {8'hB4, 24'h0}, 64'd9, 64'd3, 4'b0111, 64'd3, 64'd3, 0, 0, 0, LAT + 1);
      run("movz", {9'b110100101, 2'd2, 16'hBEEF, 5'd0}, 64'h1234, 64'd0, 4'b1110,
          64'hBEEF, 64'h0000BEEF00000000, 0, 0, 0, LAT + 1);
      run("ldur", {11'b11111000010, 9'h1F8, 12'h0}, 64'h100, 64'd0, 4'b0010,
          64'hFFFFFFFFFFFFFFF8, 64'hF8, 0, 0, 0, LAT + 1);
      run("illegal", 32'h0, 64'd1, 64'd2, 4'b0000, 64'd0, 64'd0, 0, 0, 1, 1);
      // Stall in DONE: result must hold while the consumer is not ready
      ResReady = 1'b0;
      issue({11'b10001011000, 21'h0}, 64'd1, 64'd2, lat);
      repeat (5) begin
         chk("stall_data", ResData, 64'd3);
         chk("stall_valid", 64'(ResValid), 1);
         step();
      end
      ResReady = 1'b1;
      step();
      // Reset during EXEC discards the instruction
      Instr = {11'b10001011000, 21'h0}; RegA = 64'd4; RegB = 64'd4; InstrValid = 1'b1;
      step();
      InstrValid = 1'b0;
      step();
      ResetL = 1'b0;
      step();
      chk("midrst_valid", 64'(ResValid), 0);
      chk("midrst_data", ResData, 0);
      ResetL = 1'b1;
      repeat (LAT + 3) begin
         chk("post_rst_valid", 64'(ResValid), 0);
         step();
      end
      repeat (3000) begin
         InstrValid = ($urandom_range(0, 99) < 70);
         Instr = rand_instr();
         RegA = {$urandom, $urandom};
         RegB = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
         ResReady = ($urandom_range(0, 99) < 65);
         ResetL = ($urandom_range(0, 399) != 0);
         step();
      end
      InstrValid = 1'b0;
      ResReady = 1'b1;
      ResetL = 1'b1;
      repeat (LAT + 4) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
